// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: sizes and FSM state encoding.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_RUN    = 2'd2,
    DIV_DONE   = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step on the {rem, quo} shift register.
module div_unit_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] rq,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] rq_next
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic             ge;

  // Remainder after the left shift, with one guard bit so the trial sign is exact.
  always_comb begin
    rem_sh  = rq[2*WIDTH:WIDTH-1];
    trial   = rem_sh - {2'b00, divisor};
    ge      = ~trial[WIDTH+1];
    rq_next = {(ge ? trial[WIDTH:0] : rem_sh[WIDTH:0]), rq[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32/32 restoring divider for DIV/DIVU feeding the HI/LO writeback path.
// result_o = {hi = remainder, lo = quotient}; stall_o holds EX until ready_o.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             neg_quo;
  logic             neg_rem;
  logic [2*WIDTH:0] rq;
  logic [2*WIDTH:0] rq_next;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign stall_o = start_i & ~annul_i & ~ready_o;

  // Operand magnitudes for signed mode; unsigned mode passes operands through.
  always_comb begin
    a_neg = signed_i & opdata1_i[WIDTH-1];
    b_neg = signed_i & opdata2_i[WIDTH-1];
    a_abs = a_neg ? -opdata1_i : opdata1_i;
    b_abs = b_neg ? -opdata2_i : opdata2_i;
  end

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rq      (rq),
    .divisor (divisor),
    .rq_next (rq_next)
  );

  // Sign fix on the final step: quotient by sign XOR, remainder follows the dividend.
  always_comb begin
    quo_fix = neg_quo ? -rq_next[WIDTH-1:0] : rq_next[WIDTH-1:0];
    rem_fix = neg_rem ? -rq_next[2*WIDTH-1:WIDTH] : rq_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      rq       <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      state   <= DIV_IDLE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_i) begin
            dividend <= opdata1_i;
            divisor  <= b_abs;
            neg_quo  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            rq       <= {{(WIDTH+1){1'b0}}, a_abs};
            cnt      <= '0;
            state    <= (opdata2_i == '0) ? DIV_BYZERO : DIV_RUN;
          end
        end
        DIV_BYZERO: begin
          result_o <= {dividend, {WIDTH{1'b1}}};
          ready_o  <= 1'b1;
          state    <= DIV_DONE;
        end
        DIV_RUN: begin
          rq  <= rq_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
            state    <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!start_i) begin
            ready_o <= 1'b0;
            state   <= DIV_IDLE;
          end
        end
        default: begin
          ready_o <= 1'b0;
          state   <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random DIV/DIVU
// operations checked against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: {remainder, quotient} from ordinary integer division.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) begin
      q = a / b;
      r = a % b;
      return {r, q};
    end
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Counts edges after the accept edge until ready_o, bounded.
  task automatic wait_ready(input string tag, input int exp_lat);
    int lat = 0;
    while (!ready_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] exp;
    exp       = ref_div(sgn, a, b);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    check({tag, " stall@req"}, 64'(stall_o), 64'(1));
    @(posedge clk);
    #1;
    // Operands change after accept and must not disturb the operation
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_i  = 1'($urandom);
    check({tag, " stall@N+1"}, 64'(stall_o), 64'(1));
    wait_ready(tag, (b == 32'd0) ? 1 : 32);
    check({tag, " result"}, result_o, exp);
    check({tag, " stall@ready"}, 64'(stall_o), 64'(0));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({tag, " hold ready"}, 64'(ready_o), 64'(1));
      check({tag, " hold result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready drop"}, 64'(ready_o), 64'(0));
  endtask

  task automatic watch_no_ready(input string tag, input int cycles);
    int rises = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) rises++;
    end
    check({tag, " no ready"}, 64'(rises), 64'(0));
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;

    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    @(posedge clk);
    #1;
    check("reset result", result_o, 64'h0);
    check("reset ready", 64'(ready_o), 64'(0));
    check("reset stall", 64'(stall_o), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 3);
    check("divu 100/7 const", result_o, {32'd2, 32'd14});
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    check("div -7/2 const", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    check("div 7/-2 const", result_o, {32'd1, 32'hFFFF_FFFD});
    run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div min/-1 const", result_o, {32'h0, 32'h8000_0000});
    run_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    check("divu max/1 const", result_o, {32'h0, 32'hFFFF_FFFF});
    run_op("div by zero", 1'b0, 32'h1234, 32'd0, 1);
    check("div by zero const", result_o, {32'h1234, 32'hFFFF_FFFF});

    // Annul mid-RUN: back to IDLE, result kept, ready never rises
    prev      = result_o;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul ready", 64'(ready_o), 64'(0));
    check("annul keeps result", result_o, prev);
    watch_no_ready("annul", 40);
    run_op("divu 9/3", 1'b0, 32'd9, 32'd3, 0);
    check("divu 9/3 const", result_o, {32'd0, 32'd3});

    // Asynchronous reset in the middle of RUN
    start_i   = 1'b1;
    opdata1_i = 32'd500;
    opdata2_i = 32'd7;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst ready", 64'(ready_o), 64'(0));
    check("async rst result", result_o, 64'h0);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // annul_i wins over start_i in IDLE
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    #1;
    check("start+annul stall", 64'(stall_o), 64'(0));
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    watch_no_ready("start+annul", 40);

    // start_i dropped during RUN: completes, ready pulses for one cycle
    start_i   = 1'b1;
    signed_i  = 1'b1;
    opdata1_i = 32'hFFFF_FFB3;
    opdata2_i = 32'd5;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_ready("drop start", 32);
    check("drop start result", result_o, ref_div(1'b1, 32'hFFFF_FFB3, 32'd5));
    @(posedge clk);
    #1;
    check("drop start pulse", 64'(ready_o), 64'(0));

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), sgn, a, b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
